// File: rtl/imem_dmem_arbiter_if.sv
// Fetch, data and unified-memory port bundle shared by
// the instruction/data memory arbiter and its environment.
interface imem_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_valid;
    logic            flush_i;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic [DW-1:0]   d_rdata;
    logic            d_valid;

    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_ack;
    logic [DW-1:0]   m_rdata;

    logic            stall_if;
    logic            stall_mem;

    modport master (
        input  i_req, i_addr, flush_i,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_ack, m_rdata,
        output i_rdata, i_valid, d_rdata, d_valid,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        output stall_if, stall_mem
    );

    modport slave (
        output i_req, i_addr, flush_i,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_ack, m_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between fetch and memory stages:
// data-first arbitration with a starvation limiter and flush drop.
module imem_dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    imem_dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY,
        IDROP
    } state_e;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_e          state_q, state_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [DW/8-1:0] m_wstrb_q, m_wstrb_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic            i_valid_q, i_valid_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            d_valid_q, d_valid_d;
    logic [3:0]      starve_q, starve_d;

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;

    always_comb begin
        i_elig    = bus.i_req & ~bus.flush_i & ~i_valid_q;
        d_elig    = bus.d_req & ~d_valid_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        i_rdata_d = i_rdata_q;
        i_valid_d = 1'b0;
        d_rdata_d = d_rdata_q;
        d_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // fetch overrides data only once the limiter has saturated
                if (d_elig && !(i_elig && starve_q == LIM)) begin
                    grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_d   = DBUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_wstrb_d = bus.d_wstrb;
                end else if (grant_i) begin
                    state_d   = IBUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
                end
            end
            IBUSY: begin
                if (bus.m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (!bus.flush_i) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end
                end else if (bus.flush_i) begin
                    state_d = IDROP;
                end
            end
            IDROP: begin
                if (bus.m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                end
            end
            DBUSY: begin
                if (bus.m_ack) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    d_valid_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.i_req || grant_i) begin
            starve_d = '0;
        end else if (grant_d && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            i_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_rdata_q <= '0;
            d_valid_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            i_rdata_q <= i_rdata_d;
            i_valid_q <= i_valid_d;
            d_rdata_q <= d_rdata_d;
            d_valid_q <= d_valid_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_wstrb   = m_wstrb_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.stall_if  = bus.i_req & ~i_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: directed scenarios
// plus randomized fetch/data traffic against a variable-wait memory.
module tb_imem_dmem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    imem_dmem_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIM(LIM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int fixed_wait = 0;
    int max_wait = 3;
    int mcnt = 0;
    int mwait = 0;
    int flush_mode = 0;
    logic flush_manual = 1'b0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] model_drdata = '0;
    logic [31:0] tx_addr[$];
    logic        tx_isd[$];
    int   streak = 0;
    bit   chk_starve = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5EED1234;
    endfunction

    function automatic int pick_wait();
        if (fixed_wait >= 0) return fixed_wait;
        return int'($urandom_range(0, max_wait));
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    // memory: acks after mwait extra cycles, read data is combinational
    always @(posedge clk) begin
        if (!rst_n || !bus.m_req || bus.m_ack) mcnt <= 0;
        else mcnt <= mcnt + 1;
        if (!rst_n || !bus.m_req) mwait <= pick_wait();
    end
    assign bus.m_ack   = bus.m_req && (mcnt == mwait);
    assign bus.m_rdata = mem_word(bus.m_addr);

    initial begin
        bus.flush_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (flush_mode)
                1:       bus.flush_i = ($urandom_range(0, 7) == 0);
                2:       bus.flush_i = bus.d_valid;
                3:       bus.flush_i = flush_manual;
                default: bus.flush_i = 1'b0;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic isd;
        logic ireq_prev;
        logic mreq_prev;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_we;
        ireq_prev = 1'b0;
        mreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check1("stall_if", bus.stall_if, bus.i_req & ~bus.i_valid);
                check1("stall_mem", bus.stall_mem, bus.d_req & ~bus.d_valid);
                if (bus.i_valid) begin
                    if (iq.size() == 0) begin
                        check1("i_valid_unexpected", bus.i_valid, 1'b0);
                    end else begin
                        check("i_rdata", bus.i_rdata, iq.pop_front());
                    end
                end
                if (bus.d_valid) begin
                    if (dq.size() == 0) begin
                        check1("d_valid_unexpected", bus.d_valid, 1'b0);
                    end else begin
                        check("d_rdata", bus.d_rdata, dq.pop_front());
                    end
                end
                if (bus.m_req && !mreq_prev) begin
                    isd = bus.m_we || (bus.m_addr >= 32'h2000);
                    tx_addr.push_back(bus.m_addr);
                    tx_isd.push_back(isd);
                    s_addr  = bus.m_addr;
                    s_wdata = bus.m_wdata;
                    s_wstrb = bus.m_wstrb;
                    s_we    = bus.m_we;
                    if (isd) begin
                        check("d_m_addr", bus.m_addr, bus.d_addr);
                        check1("d_m_we", bus.m_we, bus.d_we);
                        check("d_m_wdata", bus.m_wdata, bus.d_wdata);
                        check("d_m_wstrb", {28'b0, bus.m_wstrb},
                              {28'b0, bus.d_wstrb});
                        if (ireq_prev) streak++;
                        if (chk_starve)
                            check1("starve_bound", streak <= LIM, 1'b1);
                    end else begin
                        check("i_m_addr", bus.m_addr, bus.i_addr);
                        check1("i_m_we", bus.m_we, 1'b0);
                        check("i_m_wstrb", {28'b0, bus.m_wstrb}, 32'h0);
                        streak = 0;
                    end
                end else if (bus.m_req) begin
                    check("m_addr_stable", bus.m_addr, s_addr);
                    check("m_wdata_stable", bus.m_wdata, s_wdata);
                    check("m_wstrb_stable", {28'b0, bus.m_wstrb},
                          {28'b0, s_wstrb});
                    check1("m_we_stable", bus.m_we, s_we);
                end
                if (!bus.i_req) streak = 0;
                ireq_prev = bus.i_req;
            end else begin
                streak = 0;
                ireq_prev = 1'b0;
            end
            mreq_prev = bus.m_req;
        end
    end

    task automatic fetch(input logic [31:0] a, output int lat);
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        iq.push_back(mem_word(a));
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.i_valid && lat < 400);
        if (!bus.i_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout %h: no i_valid in %0d cycles", a, lat);
        end
        bus.i_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output int lat);
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_wstrb = ws;
        bus.d_req   = 1'b1;
        if (!we) model_drdata = mem_word(a);
        dq.push_back(model_drdata);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.d_valid && lat < 400);
        if (!bus.d_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL data_timeout %h: no d_valid in %0d cycles", a, lat);
        end
        bus.d_req = 1'b0;
    endtask

    task automatic rand_fetches(input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            fetch(32'h100 + 32'($urandom_range(0, 1983)) * 4, lat);
        end
    endtask

    task automatic rand_data(input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            data(1'($urandom_range(0, 1)),
                 32'h2000 + 32'($urandom_range(0, 2047)) * 4,
                 $urandom, 4'($urandom_range(0, 15)), lat);
        end
    endtask

    initial begin
        int lat;
        int lat2;
        int base;
        int nd;
        logic [31:0] keep;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_m_req", bus.m_req, 1'b0);
        check1("rst_i_valid", bus.i_valid, 1'b0);
        check1("rst_d_valid", bus.d_valid, 1'b0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_starve", {28'b0, dut.starve_q}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fixed_wait = 0;
        fetch(32'h100, lat);
        check("fetch_latency", lat, 2);
        check("fetch_rdata", bus.i_rdata, 32'hDEADBEEF);

        @(posedge clk);
        #1;
        base = tx_addr.size();
        fork
            fetch(32'h180, lat);
            data(1'b0, 32'h2000, 32'h0, 4'h0, lat2);
        join
        check("cont_d_latency", lat2, 2);
        check("cont_i_latency", lat, 4);
        check("cont_first_addr", tx_addr[base], 32'h2000);
        check("cont_second_addr", tx_addr[base+1], 32'h180);

        @(posedge clk);
        #1;
        base = tx_addr.size();
        flush_mode = 2;
        fork
            begin
                fetch(32'h104, lat);
                check("starve_cnt_clear", {28'b0, dut.starve_q}, 32'h0);
            end
            for (int k = 0; k < 6; k++)
                data(1'b0, 32'h2000 + 32'(k) * 16, 32'h0, 4'h0, lat2);
        join
        flush_mode = 0;
        nd = 0;
        for (int k = base; k < tx_addr.size() && tx_isd[k]; k++) nd++;
        check("starve_data_before_fetch", nd, LIM);
        check("starve_fetch_addr", tx_addr[base+LIM], 32'h104);

        @(posedge clk);
        #1;
        base = tx_addr.size();
        fixed_wait = 3;
        flush_mode = 3;
        fork
            fetch(32'h1A0, lat);
            begin
                @(posedge clk);
                flush_manual = 1'b1;
                @(posedge clk);
                flush_manual = 1'b0;
                repeat (3) begin
                    #2;
                    check1("idrop_m_req", bus.m_req, 1'b1);
                    check1("idrop_no_ivalid", bus.i_valid, 1'b0);
                    @(posedge clk);
                end
            end
        join
        flush_mode = 0;
        check("flush_latency", lat, 10);
        check("flush_tx_count", tx_addr.size() - base, 2);
        check("flush_refetch_addr", tx_addr[base+1], 32'h1A0);

        @(posedge clk);
        #1;
        fixed_wait = 2;
        keep = model_drdata;
        data(1'b1, 32'h40, 32'h11223344, 4'b0011, lat);
        check("store_latency", lat, 4);
        check("store_rdata_hold", bus.d_rdata, keep);
        check("store_addr", tx_addr[tx_addr.size()-1], 32'h40);

        @(posedge clk);
        #1;
        fixed_wait = 5;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h2468;
        bus.d_req  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check1("pre_reset_m_req", bus.m_req, 1'b1);
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_drdata = '0;
        check1("midrst_m_req", bus.m_req, 1'b0);
        check1("midrst_d_valid", bus.d_valid, 1'b0);
        check1("midrst_i_valid", bus.i_valid, 1'b0);
        check("midrst_d_rdata", bus.d_rdata, 32'h0);
        fixed_wait = 0;
        data(1'b0, 32'h2468, 32'h0, 4'h0, lat);
        check("post_reset_latency", lat, 2);

        fixed_wait = -1;
        max_wait = 3;
        chk_starve = 1;
        fork
            rand_fetches(40);
            rand_data(40);
        join
        chk_starve = 0;
        flush_mode = 1;
        fork
            rand_fetches(40);
            rand_data(40);
        join
        flush_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
